// File: rtl/aes_key_schedule_gen.sv
// Iterative AES-128 key expansion: one round key per clock, packed last-round-first
// into an 11-slice schedule bus for the downstream inverse cipher.
module aes_key_schedule_gen (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [127:0]  key,
    output logic [1407:0] wordout,
    output logic          busy,
    output logic          done,
    output logic          key_valid
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      rnd_q, rnd_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [127:0]    prev_q, prev_d;
    logic [1407:0]   wordout_q, wordout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            key_valid_q, key_valid_d;

    logic [31:0]     p0, p1, p2, p3, rot, t, n0, n1, n2, n3;
    logic [127:0]    next_rk;
    logic [3:0]      slot;

    // Round function: RotWord, four parallel S-box lookups, rcon, then the XOR chain.
    always_comb begin
        {p0, p1, p2, p3} = prev_q;
        rot     = {p3[23:0], p3[31:24]};
        t       = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                  ^ {rcon_q, 24'h0};
        n0      = p0 ^ t;
        n1      = p1 ^ n0;
        n2      = p2 ^ n1;
        n3      = p3 ^ n2;
        next_rk = {n0, n1, n2, n3};
        slot    = 4'd10 - rnd_q;
    end

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        rcon_d      = rcon_q;
        prev_d      = prev_q;
        wordout_d   = wordout_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wordout_d[1280 +: 128] = key;
                    prev_d      = key;
                    rnd_d       = 4'd1;
                    rcon_d      = 8'h01;
                    key_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = EXPAND;
                end
            end
            EXPAND: begin
                for (int k = 0; k < 11; k++) begin
                    if (slot == 4'(k)) wordout_d[k*128 +: 128] = next_rk;
                end
                prev_d = next_rk;
                rnd_d  = rnd_q + 4'd1;
                rcon_d = xtime(rcon_q);
                if (rnd_q == 4'd10) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            rcon_q      <= 8'h01;
            prev_q      <= '0;
            wordout_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            rcon_q      <= rcon_d;
            prev_q      <= prev_d;
            wordout_q   <= wordout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign wordout   = wordout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;

endmodule
